shl_flags_pipe: RTL
===================

// Module: shl_flags_pipe
// PURPOSE
//  2-stage pipelined left-shift unit (SHL/SAL) for the execute stage. It pairs with the arithmetic
//  right-shift path. Shifts 8/16/32-bit operands left by a 5-bit count and generates x86 status
//  flags. It uses a valid/ready handshake so execute-stage stalls can backpressure it without losing ops.
// PARAMETERS
//  WIDTH   32   datapath width; only 32 is supported
//  AMT_W   5    count width, $clog2(WIDTH)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous reset, active-high
//  flush         in   1   synchronous kill of all in-flight ops (branch mispredict/exception)
//  in_valid      in   1   operand set valid
//  in_ready      out  1   unit can accept this cycle
//  in_data       in   32  operand; only low 8/16 bits are used for 8/16-bit sizes
//  in_count      in   5   shift count, already masked to 5 bits
//  in_op_size    in   2   00=8b, 01=16b, 10=32b, 11=reserved
//  out_valid     out  1   result valid
//  out_ready     in   1   downstream accepts result
//  out_data      out  32  result, zero above the op size
//  out_flags     out  6   {OF,SF,ZF,AF,PF,CF}, bit indices 5..0
//  out_flags_we  out  1   1 = flags must be written; 0 = EFLAGS unchanged
// BEHAVIOUR
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_flags=0, out_flags_we=0, in_ready=1.
//  - Handshake: transfer occurs when valid&&ready.
//     s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//     in_ready has no combinational dependence on in_valid.
//  - S1 registers the operands and performs the 33-bit shift {1'b0,data}<<count. It also registers
//    the count-zero and count>size indications.
//  - S2 computes the flags and registers the result.
//  - Latency: exactly 2 cycles from accept to out_valid when no stall occurs. Throughput is 1 op/cycle.
//  - out_* hold stable while out_valid&&!out_ready.
//  - Result: data<<count truncated to the op size, with upper bits forced to 0.
//  - Let N be the op size (8/16/32):
//     CF = bit N of the 33-bit shifted operand (the last bit shifted out) when 1<=count<=N.
//     CF = 0 when count>N.
//     SF = result[N-1].  ZF = (result[N-1:0]==0).  PF = even parity of result[7:0].
//     AF = 0.  OF = result[N-1] ^ CF for every nonzero count.
//  - count==0: out_data=in_data masked to size, out_flags=0, out_flags_we=0.
//  - count>N (8/16-bit only): result=0, CF=0, ZF=1, PF=1, SF=0, OF=0, out_flags_we=1.
//  - op_size==11: out_data=0, out_flags=0, out_flags_we=0. The op still flows through the pipeline.
//  - flush: s1_valid and s2_valid clear next cycle, and any op presented that same cycle is dropped.
//    flush has priority over simultaneous accept and out_ready.
//  - rst has priority over flush. Asserting rst mid-operation discards all ops and restores reset values.
// STRUCTURE
//  - Shared execute package holds: flag index constants CF=0,PF=1,AF=2,ZF=3,SF=4,OF=5;
//    size encodings SZ8/SZ16/SZ32; FLAG_W=6.
//  - One sub-module: bit_shift_left_flgs, a mux2$ log-shifter with 33-bit out_cf and a count-zero
//    output. It mirrors the right-shift structure in the opposite direction.
//  - Flag generation stays inline and reuses the existing zero8/16/32, parity, and
//    mux_nbit_4x1 cells.
// TESTING
//  - 8b, 0x81, count 1 -> out_data=0x02, CF=1, OF=1, SF=0, ZF=0, PF=0, we=1; out_valid 2 cycles later.
//  - 32b, 0x40000000, count 1 -> 0x80000000, CF=0, SF=1, OF=1, ZF=0, PF=1.
//  - 16b, 0x0001, count 16 -> 0x0000, CF=1, ZF=1, PF=1, OF=1.
//  - 8b, 0xFF, count 20 -> out_data=0, CF=0, ZF=1, PF=1, OF=0, we=1.
//  - 32b, 0x12345678, count 0 -> out_data unchanged, we=0.
//  - Backpressure: 4 back-to-back ops with out_ready=0 for 3 cycles.
//     in_ready drops after 2 ops are held. Order is preserved and no op is lost or duplicated.
//  - flush with 2 ops in flight -> neither emerges, and the next op has 2-cycle latency.
//  - rst mid-stream -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/shl_flags_pipe_pkg.sv
// Shared execute-stage definitions: flag bit positions, operand size encodings, pipeline records.
// Pure declarations; no timing or flow-control behaviour of its own.
package shl_flags_pipe_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;
   localparam int FLAG_W = 6;

   localparam int CF = 0;
   localparam int PF = 1;
   localparam int AF = 2;
   localparam int ZF = 3;
   localparam int SF = 4;
   localparam int OF = 5;

   typedef enum logic [1:0] {
      SZ8    = 2'b00,
      SZ16   = 2'b01,
      SZ32   = 2'b10,
      SZ_RSV = 2'b11
   } op_size_e;

   typedef struct packed {
      logic [DATA_W:0] shifted;
      op_size_e        size;
      logic            cnt_zero;
      logic            cnt_over;
   } s1_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [FLAG_W-1:0] flags;
      logic              flags_we;
   } s2_t;

   function automatic logic [DATA_W-1:0] size_mask(input op_size_e sz);
      case (sz)
         SZ8:     return 32'h0000_00FF;
         SZ16:    return 32'h0000_FFFF;
         SZ32:    return 32'hFFFF_FFFF;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/shl_flags_pipe_bit_shift_left_flgs.sv
// Log-shifter producing {1'b0,data}<<count as 33 bits so bit N holds the last bit shifted out.
// Purely combinational; no flow control.
module bit_shift_left_flgs
   import shl_flags_pipe_pkg::*;
(
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_count,
   output logic [DATA_W:0]   out_cf,
   output logic              count_zero
);

   logic [CNT_W:0][DATA_W:0] stg;

   assign stg[0] = {1'b0, in_data};

   for (genvar k = 0; k < CNT_W; k++) begin : g_stage
      localparam int SH = 1 << k;
      assign stg[k+1] = in_count[k] ? {stg[k][DATA_W-SH:0], {SH{1'b0}}} : stg[k];
   end

   assign out_cf     = stg[CNT_W];
   assign count_zero = (in_count == '0);

endmodule

// File: rtl/shl_flags_pipe.sv
// 2-stage SHL/SAL unit with x86 flags; accept-to-out_valid latency 2 cycles, 1 op/cycle.
// Valid/ready backpressure stalls S2 then S1; flush kills both stages and any op offered that cycle.
module shl_flags_pipe
   import shl_flags_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [AMT_W-1:0]  in_count,
   input  logic [1:0]        in_op_size,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [FLAG_W-1:0] out_flags,
   output logic              out_flags_we
);

   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;

   logic s1_adv, s2_adv;
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   op_size_e          in_size_w;
   logic [WIDTH-1:0]  masked_w;
   logic [WIDTH:0]    shifted_w;
   logic              cnt_zero_w;
   logic              cnt_over_w;

   assign in_size_w = op_size_e'(in_op_size);
   assign masked_w  = in_data & size_mask(in_size_w);

   bit_shift_left_flgs u_shl (
      .in_data    (masked_w),
      .in_count   (in_count),
      .out_cf     (shifted_w),
      .count_zero (cnt_zero_w)
   );

   // Only narrow sizes can be over-shifted; a 5-bit count never exceeds 32.
   assign cnt_over_w = ((in_size_w == SZ8)  && (in_count > 5'd8)) ||
                       ((in_size_w == SZ16) && (in_count > 5'd16));

   always_comb begin
      s1_d = s1_q;
      if (s1_adv && in_valid) begin
         s1_d.shifted  = shifted_w;
         s1_d.size     = in_size_w;
         s1_d.cnt_zero = cnt_zero_w;
         s1_d.cnt_over = cnt_over_w;
      end
   end

   logic [WIDTH-1:0]  res_w;
   logic [FLAG_W-1:0] flags_w;
   logic              cf_w, sf_w;
   s2_t               s2_nxt;

   always_comb begin
      res_w = '0;
      cf_w  = 1'b0;
      sf_w  = 1'b0;
      case (s1_q.size)
         SZ8: begin
            res_w = {24'b0, s1_q.shifted[7:0]};
            cf_w  = s1_q.shifted[8];
            sf_w  = s1_q.shifted[7];
         end
         SZ16: begin
            res_w = {16'b0, s1_q.shifted[15:0]};
            cf_w  = s1_q.shifted[16];
            sf_w  = s1_q.shifted[15];
         end
         SZ32: begin
            res_w = s1_q.shifted[31:0];
            cf_w  = s1_q.shifted[32];
            sf_w  = s1_q.shifted[31];
         end
         default: begin
            res_w = '0;
         end
      endcase
      if (s1_q.cnt_over) cf_w = 1'b0;

      flags_w     = '0;
      flags_w[CF] = cf_w;
      flags_w[PF] = ~^res_w[7:0];
      flags_w[AF] = 1'b0;
      flags_w[ZF] = (res_w == '0);
      flags_w[SF] = sf_w;
      flags_w[OF] = sf_w ^ cf_w;

      s2_nxt.data     = res_w;
      s2_nxt.flags    = flags_w;
      s2_nxt.flags_we = 1'b1;
      if (s1_q.cnt_zero) begin
         s2_nxt.flags    = '0;
         s2_nxt.flags_we = 1'b0;
      end
      if (s1_q.size == SZ_RSV) begin
         s2_nxt.data     = '0;
         s2_nxt.flags    = '0;
         s2_nxt.flags_we = 1'b0;
      end
   end

   always_comb begin
      s2_d = s2_q;
      if (s2_adv && s1_valid_q) s2_d = s2_nxt;
   end

   // Flush wins over both accept and drain; data registers are don't-care once valid is low.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s2_adv) s2_valid_d = s1_valid_q;
         if (s1_adv) s1_valid_d = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_data     = s2_q.data;
   assign out_flags    = s2_q.flags;
   assign out_flags_we = s2_q.flags_we;

endmodule
